ru_param_arbiter: RTL and testbench

- Shares the Remote Update megafunction's parameter port (param, data_in, write_param, read_param, read_source, busy, data_out) between NUM_REQ requesters, e.g. the boot sequencer and a network command handler that reads config status.
- Owns the strobe/busy handshake: one transaction at a time, round-robin grant, with a busy timeout so a hung IP cannot stall the bootloader.
- Sits between the requesters and the Remote instance; also drives the megafunction reset at power-up.

---
 rtl/ru_pkg.sv | 27 ++
 rtl/ru_param_arbiter_rr_pick.sv | 27 ++
 rtl/ru_param_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ru_param_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ru_pkg.sv
// Shared definitions for the Remote Update parameter-port arbiter:
// parameter codes, FSM state encoding and timeout counter width.
package ru_pkg;

  localparam logic [2:0] CONFIG_DONE_EARLY = 3'b001;
  localparam logic [2:0] WATCHDOG_EN       = 3'b011;
  localparam logic [2:0] BOOT_ADDR         = 3'b100;
  localparam logic [2:0] OSC_INT           = 3'b110;
  localparam logic [2:0] RECONFIG_REASON   = 3'b111;

  localparam int TMO_W = 10;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_GAP,
    ST_WAIT,
    ST_DONE,
    ST_VSETUP,
    ST_VSTROBE,
    ST_VGAP,
    ST_VWAIT
  } ru_state_e;

endpackage

// File: rtl/ru_param_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N; returns one-hot grant, its index and an any flag.
module rr_pick #(
  parameter int N    = 2,
  parameter int IDXW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any                          = 1'b1;
        grant[(int'(ptr) + i) % N]   = 1'b1;
        idx                          = IDXW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/ru_param_arbiter.sv
// Arbitrates NUM_REQ requesters onto the Remote Update parameter port with a
// busy timeout. Define RU_READBACK_VERIFY_EN to read back and check every write.
//
// state    | meaning
// INIT     | hold IP in reset until it drops busy
// IDLE     | pick next requester round-robin, latch its fields
// SETUP    | param/data stable one cycle before strobe
// STROBE   | one-cycle write_param/read_param pulse
// GAP      | BUSY_GAP cycles before busy is trusted
// WAIT     | wait for busy low or timeout
// DONE     | ack pulse, advance round-robin pointer
// V*       | same sequence as a read-back of the written param
module ru_param_arbiter
  import ru_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int BUSY_GAP = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [3*NUM_REQ-1:0]  req_param,
  input  logic [2*NUM_REQ-1:0]  req_source,
  input  logic [22*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic [23:0]           rd_data,
  output logic                  err_timeout,
  output logic                  err_verify,
  output logic                  ru_reset,
  output logic [2:0]            ru_param,
  output logic [1:0]            ru_read_source,
  output logic [21:0]           ru_data_in,
  output logic                  ru_write_param,
  output logic                  ru_read_param,
  input  logic                  ru_busy,
  input  logic [23:0]           ru_data_out
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ru_state_e          state, state_nxt;
  logic [NUM_REQ-1:0] pick_grant, grant_q;
  logic [IDXW-1:0]    pick_idx, grant_idx, rr_ptr;
  logic               pick_any, wr_q;
  logic [7:0]         gap_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               busy_tmo, wait_end;

  rr_pick #(.N(NUM_REQ), .IDXW(IDXW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign busy_tmo = ru_busy && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign wait_end = !ru_busy || busy_tmo;

  always_comb begin
    state_nxt      = state;
    ru_reset       = 1'b0;
    ru_write_param = 1'b0;
    ru_read_param  = 1'b0;
    ack            = '0;
    case (state)
      ST_INIT: begin
        ru_reset = 1'b1;
        if (!ru_busy) state_nxt = ST_IDLE;
      end
      ST_IDLE:   if (pick_any) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_STROBE;
      ST_STROBE: begin
        ru_write_param = wr_q;
        ru_read_param  = !wr_q;
        state_nxt      = ST_GAP;
      end
      ST_GAP:    if (gap_cnt == '0) state_nxt = ST_WAIT;
      ST_WAIT: begin
`ifdef RU_READBACK_VERIFY_EN
        if (wait_end) state_nxt = (wr_q && !busy_tmo) ? ST_VSETUP : ST_DONE;
`else
        if (wait_end) state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        ack       = grant_q;
        state_nxt = ST_IDLE;
      end
`ifdef RU_READBACK_VERIFY_EN
      ST_VSETUP:  state_nxt = ST_VSTROBE;
      ST_VSTROBE: begin
        ru_read_param = 1'b1;
        state_nxt     = ST_VGAP;
      end
      ST_VGAP:    if (gap_cnt == '0) state_nxt = ST_VWAIT;
      ST_VWAIT:   if (wait_end) state_nxt = ST_DONE;
`endif
      default:    state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= ST_INIT;
      grant_q        <= '0;
      grant_idx      <= '0;
      rr_ptr         <= '0;
      wr_q           <= 1'b0;
      gap_cnt        <= '0;
      tmo_cnt        <= '0;
      rd_data        <= '0;
      err_timeout    <= 1'b0;
      ru_param       <= '0;
      ru_read_source <= '0;
      ru_data_in     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (pick_any) begin
          grant_q        <= pick_grant;
          grant_idx      <= pick_idx;
          wr_q           <= req_write[pick_idx];
          ru_param       <= req_param[3*int'(pick_idx) +: 3];
          ru_read_source <= req_source[2*int'(pick_idx) +: 2];
          ru_data_in     <= req_data[22*int'(pick_idx) +: 22];
        end
        ST_STROBE, ST_VSTROBE: gap_cnt <= 8'(BUSY_GAP - 1);
        ST_GAP, ST_VGAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        // wr_q stays set through the verify read, so rd_data is left untouched there
        ST_WAIT, ST_VWAIT: begin
          if (wait_end) begin
            tmo_cnt <= '0;
            if (busy_tmo) begin
              err_timeout <= 1'b1;
              if (!wr_q) rd_data <= '1;
            end else if (!wr_q) begin
              rd_data <= ru_data_out;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DONE: rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RU_READBACK_VERIFY_EN
  always_ff @(posedge clock) begin
    if (!reset) err_verify <= 1'b0;
    else if (state == ST_VWAIT && !ru_busy && ru_data_out[21:0] != ru_data_in)
      err_verify <= 1'b1;
  end
`else
  assign err_verify = 1'b0;
`endif

endmodule

// File: tb/tb_ru_param_arbiter.sv
// Directed + randomized bench for ru_param_arbiter with a behavioural IP model
// and a round-robin reference model; set RU_READBACK_VERIFY_EN to cover read-back.
module tb_ru_param_arbiter;
  import ru_pkg::*;

  localparam int N   = 2;
  localparam int TMO = 1023;
`ifdef RU_READBACK_VERIFY_EN
  localparam int WR_STROBES = 2;
  localparam int WR_LAT     = 0;
`else
  localparam int WR_STROBES = 1;
  localparam int WR_LAT     = 8;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_write;
  logic [3*N-1:0]  req_param;
  logic [2*N-1:0]  req_source;
  logic [22*N-1:0] req_data;
  logic [N-1:0]    ack;
  logic [23:0]     rd_data;
  logic            err_timeout, err_verify, ru_reset;
  logic [2:0]      ru_param;
  logic [1:0]      ru_read_source;
  logic [21:0]     ru_data_in;
  logic            ru_write_param, ru_read_param;
  logic            ru_busy = 1'b0;
  logic [23:0]     ru_data_out;

  ru_param_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_param(req_param), .req_source(req_source), .req_data(req_data),
    .ack(ack), .rd_data(rd_data), .err_timeout(err_timeout), .err_verify(err_verify),
    .ru_reset(ru_reset), .ru_param(ru_param), .ru_read_source(ru_read_source),
    .ru_data_in(ru_data_in), .ru_write_param(ru_write_param),
    .ru_read_param(ru_read_param), .ru_busy(ru_busy), .ru_data_out(ru_data_out)
  );

  always #5 clock = ~clock;

  // IP model: each strobe raises busy for busy_len negedges; stuck forces busy high.
  int   busy_len = 0, busy_left = 0, strobe_bad = 0;
  bit   stuck = 1'b0, strobe_prev = 1'b0;
  logic [2:0]  s_param[$];
  logic [1:0]  s_src[$];
  logic [21:0] s_data[$];
  bit          s_wr[$];
  always @(negedge clock) begin
    if (ru_write_param || ru_read_param) begin
      s_param.push_back(ru_param);
      s_src.push_back(ru_read_source);
      s_data.push_back(ru_data_in);
      s_wr.push_back(ru_write_param);
      if ((ru_write_param && ru_read_param) || strobe_prev) strobe_bad++;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    strobe_prev = ru_write_param || ru_read_param;
    ru_busy = stuck || (busy_left > 0);
  end

  int n_ack = 0, ack_b2b = 0, ack_bad = 0;
  bit ack_prev = 1'b0;
  always @(negedge clock) begin
    if (ack != '0) begin
      n_ack++;
      if (ack_prev) ack_b2b++;
      if (!$onehot(ack)) ack_bad++;
    end
    ack_prev = (ack != '0);
  end

  int n_assert = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference state: round-robin pointer, held read data, sticky timeout.
  int          m_ptr = 0;
  logic [23:0] m_rd  = '0;
  bit          m_err = 1'b0;
  bit          e_wr[N];
  logic [2:0]  e_param[N];
  logic [1:0]  e_src[N];
  logic [21:0] e_data[N];

  function automatic int rr_model(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input bit w, input logic [2:0] p,
                         input logic [1:0] s, input logic [21:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_param[3*i +: 3]   = p;
    req_source[2*i +: 2]  = s;
    req_data[22*i +: 22]  = d;
  endtask

  task automatic rand_req(input int i);
    e_wr[i]    = 1'($urandom);
    e_param[i] = 3'($urandom);
    e_src[i]   = 2'($urandom);
    e_data[i]  = 22'($urandom);
    set_req(i, 1'b1, e_wr[i], e_param[i], e_src[i], e_data[i]);
  endtask

  task automatic check_txn(input string tag, input int i, input bit w, input logic [2:0] p,
                           input logic [1:0] s, input logic [21:0] d, input int sidx,
                           input logic [23:0] exp_rd, input bit got);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    check({tag, "_ack_seen"}, 64'(got), 64'(1));
    if (!got) return;
    check({tag, "_ack_grant"}, 64'(ack), 64'(oh));
    check({tag, "_strobes"}, 64'(s_param.size()), 64'(sidx + (w ? WR_STROBES : 1)));
    if (s_param.size() > sidx) begin
      check({tag, "_param"}, 64'(s_param[sidx]), 64'(p));
      check({tag, "_kind"}, 64'(s_wr[sidx]), 64'(w));
      check({tag, "_src"}, 64'(s_src[sidx]), 64'(s));
      check({tag, "_data_in"}, 64'(s_data[sidx]), 64'(d));
    end
    check({tag, "_rd_data"}, 64'(rd_data), 64'(exp_rd));
    m_rd  = exp_rd;
    m_ptr = (i + 1) % N;
  endtask

  // One isolated request; the requester scrambles its fields and drops valid after latch.
  task automatic single(input string tag, input int i, input bit w, input logic [2:0] p,
                        input logic [1:0] s, input logic [21:0] d, input logic [23:0] dout,
                        input int blen, input bit tmo, input int exp_lat);
    int sidx, lat;
    bit got;
    logic [23:0] exp_rd;
    ru_data_out = dout;
    busy_len    = blen;
    sidx        = s_param.size();
    set_req(i, 1'b1, w, p, s, d);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 2000) begin
      @(negedge clock);
      lat++;
      if (lat == 1) set_req(i, 1'b0, ~w, ~p, ~s, ~d);
      got = (ack != '0);
    end
    exp_rd = w ? m_rd : (tmo ? 24'hFFFFFF : dout);
    m_err  = m_err | tmo;
    if (exp_lat > 0 && got) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_txn(tag, i, w, p, s, d, sidx, exp_rd, got);
    check({tag, "_err_timeout"}, 64'(err_timeout), 64'(m_err));
    @(negedge clock);
    check({tag, "_ack_drop"}, 64'(ack), 64'(0));
  endtask

  // Several requesters pending at once; optionally re-request after each ack.
  task automatic batch(input string tag, input logic [N-1:0] mask, input int ntx, input bit rereq);
    int exp_i, sidx, cnt;
    bit got;
    logic [23:0] dout;
    for (int i = 0; i < N; i++) if (mask[i]) rand_req(i);
    for (int t = 0; t < ntx; t++) begin
      exp_i = rr_model(req_valid, m_ptr);
      if (exp_i < 0) break;
      dout        = 24'($urandom);
      ru_data_out = dout;
      busy_len    = $urandom_range(0, 6);
      sidx        = s_param.size();
      got = 1'b0;
      cnt = 0;
      while (!got && cnt < 200) begin
        @(negedge clock);
        cnt++;
        got = (ack != '0);
      end
      check_txn(tag, exp_i, e_wr[exp_i], e_param[exp_i], e_src[exp_i], e_data[exp_i], sidx,
                e_wr[exp_i] ? m_rd : dout, got);
      if (rereq) rand_req(exp_i);
      else req_valid[exp_i] = 1'b0;
    end
    req_valid = '0;
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n_ack0;
    logic [N-1:0] mk;
    bit rr;
    reset = 1'b0;
    req_valid = '0; req_write = '0; req_param = '0; req_source = '0; req_data = '0;
    ru_data_out = '0;
    stuck = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ru_reset", 64'(ru_reset), 64'(1));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_err_timeout", 64'(err_timeout), 64'(0));
    check("rst_strobes", 64'({ru_write_param, ru_read_param}), 64'(0));
    check("rst_ru_fields", 64'({ru_param, ru_read_source, ru_data_in}), 64'(0));
    check("rst_err_verify", 64'(err_verify), 64'(0));
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("init_hold_busy", 64'(ru_reset), 64'(1));
    stuck = 1'b0;
    repeat (3) @(negedge clock);
    check("init_release", 64'(ru_reset), 64'(0));

    single("wr0", 0, 1'b1, BOOT_ADDR, 2'b00, 22'h0A0000, 24'h0, 5, 1'b0, WR_LAT);
    single("rd1", 1, 1'b0, RECONFIG_REASON, 2'b01, 22'h0, 24'h00000B, 0, 1'b0, 6);
    batch("contend", 2'b11, 4, 1'b1);

    for (int b = 0; b < 8; b++) begin
      mk = N'($urandom_range(1, (1 << N) - 1));
      rr = 1'($urandom);
      batch("rand", mk, rr ? int'($urandom_range(2, 5)) : $countones(mk), rr);
    end

    stuck = 1'b1;
    single("tmo_rd", 0, 1'b0, CONFIG_DONE_EARLY, 2'b11, 22'h3, 24'h000055, 0, 1'b1, TMO + 5);
    stuck = 1'b0;
    @(negedge clock);
    single("post_tmo", 1, 1'b0, OSC_INT, 2'b10, 22'h7, 24'hABCDEF, 2, 1'b0, 0);

    n_ack0 = n_ack;
    stuck = 1'b1;
    busy_len = 0;
    set_req(0, 1'b1, 1'b0, RECONFIG_REASON, 2'b01, 22'h0);
    repeat (12) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    req_valid = '0;
    check("rst_mid_ru_reset", 64'(ru_reset), 64'(1));
    check("rst_mid_strobes", 64'({ru_write_param, ru_read_param}), 64'(0));
    check("rst_mid_ack", 64'(ack), 64'(0));
    check("rst_mid_err_clr", 64'(err_timeout), 64'(0));
    check("rst_mid_rd_data", 64'(rd_data), 64'(0));
    repeat (5) @(negedge clock);
    check("rst_mid_init_hold", 64'(ru_reset), 64'(1));
    check("rst_mid_no_ack", 64'(n_ack), 64'(n_ack0));
    m_ptr = 0; m_rd = '0; m_err = 1'b0;
    stuck = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_mid_init_exit", 64'(ru_reset), 64'(0));
    single("post_rst", 1, 1'b0, OSC_INT, 2'b10, 22'h15, 24'h123456, 2, 1'b0, 6);

`ifdef RU_READBACK_VERIFY_EN
    single("vfy_ok", 0, 1'b1, BOOT_ADDR, 2'b00, 22'h0002A5, 24'h0002A5, 1, 1'b0, 0);
    check("vfy_ok_flag", 64'(err_verify), 64'(0));
    single("vfy_bad", 1, 1'b1, WATCHDOG_EN, 2'b00, 22'h000001, 24'h000000, 1, 1'b0, 0);
    check("vfy_bad_flag", 64'(err_verify), 64'(1));
`else
    check("no_verify_flag", 64'(err_verify), 64'(0));
`endif

    check("ack_back_to_back", 64'(ack_b2b), 64'(0));
    check("ack_onehot", 64'(ack_bad), 64'(0));
    check("strobe_shape", 64'(strobe_bad), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
